// File: rtl/seg_serial_adder_pkg.sv
// rtl/seg_serial_adder_pkg.sv - shared types and helpers for the segmented serial adder
package seg_serial_adder_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    function automatic int ceil_div(input int n, input int d);
        return (n + d - 1) / d;
    endfunction

endpackage

// File: rtl/seg_adder_slice.sv
// rtl/seg_adder_slice.sv - combinational SEG-bit ripple adder with a live-width limit
module seg_adder_slice #(
    parameter int SEG = 25
) (
    input  logic [SEG-1:0]           i_a,
    input  logic [SEG-1:0]           i_b,
    input  logic                     i_cin,
    input  logic [$clog2(SEG+1)-1:0] i_limit,
    output logic [SEG-1:0]           o_sum,
    output logic                     o_cout,
    output logic                     o_ctop
);

    logic [SEG:0] w_c;

    // Carries are tapped at the limit so a short final segment reports its own top bit.
    always_comb begin
        w_c = '0;
        w_c[0] = i_cin;
        for (int i = 0; i < SEG; i++) begin
            w_c[i+1] = (i_a[i] & i_b[i]) | (i_a[i] & w_c[i]) | (i_b[i] & w_c[i]);
        end
        o_sum  = i_a ^ i_b ^ w_c[SEG-1:0];
        o_cout = w_c[i_limit];
        o_ctop = w_c[i_limit - 1'b1];
    end

endmodule

// File: rtl/seg_serial_adder.sv
// rtl/seg_serial_adder.sv - multi-cycle wide add/subtract, one SEG-bit segment per clock
module seg_serial_adder
    import seg_serial_adder_pkg::*;
#(
    parameter int WIDTH = 100,
    parameter int SEG   = 25
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    input  logic             Sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout,
    output logic             Ovf
);

    localparam int NSEG   = ceil_div(WIDTH, SEG);
    localparam int CW     = (NSEG > 1) ? $clog2(NSEG) : 1;
    localparam int LW     = $clog2(SEG + 1);
    localparam int LAST_W = WIDTH - (NSEG - 1) * SEG;

    state_t           r_state;
    state_t           w_next;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry;
    logic             r_cout;
    logic             r_ovf;

    logic             w_last;
    logic [31:0]      w_shift;
    logic [SEG-1:0]   w_a_seg;
    logic [SEG-1:0]   w_b_seg;
    logic [SEG-1:0]   w_seg_sum;
    logic [LW-1:0]    w_limit;
    logic             w_seg_cout;
    logic             w_seg_ctop;
    logic [WIDTH-1:0] w_mask;
    logic [WIDTH-1:0] w_sum_pos;

    assign w_last    = (r_cnt == CW'(NSEG - 1));
    assign w_shift   = 32'(r_cnt) * 32'(SEG);
    assign w_a_seg   = SEG'(r_a >> w_shift);
    assign w_b_seg   = SEG'(r_b >> w_shift);
    assign w_limit   = w_last ? LW'(LAST_W) : LW'(SEG);
    // Bits of the final segment beyond WIDTH-1 fall off the top of these shifts.
    assign w_mask    = WIDTH'({SEG{1'b1}}) << w_shift;
    assign w_sum_pos = WIDTH'(w_seg_sum) << w_shift;

    seg_adder_slice #(.SEG(SEG)) u_slice (
        .i_a     (w_a_seg),
        .i_b     (w_b_seg),
        .i_cin   (r_carry),
        .i_limit (w_limit),
        .o_sum   (w_seg_sum),
        .o_cout  (w_seg_cout),
        .o_ctop  (w_seg_ctop)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (in_valid) w_next = S_RUN;
            S_RUN:   if (w_last) w_next = S_DONE;
            S_DONE:  if (out_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (r_state == S_IDLE);
        out_valid = (r_state == S_DONE);
    end

    // Subtraction is A + ~B + ~Borrow, so B and the carry are pre-inverted at capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_a     <= A;
                        r_b     <= B ^ {WIDTH{Sub}};
                        r_carry <= Cin ^ Sub;
                        r_cnt   <= '0;
                    end
                end
                S_RUN: begin
                    r_sum   <= (r_sum & ~w_mask) | (w_sum_pos & w_mask);
                    r_carry <= w_seg_cout;
                    r_cnt   <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_cout <= w_seg_cout;
                        r_ovf  <= w_seg_cout ^ w_seg_ctop;
                    end
                end
                default: ;
            endcase
        end
    end

    assign Sum  = r_sum;
    assign Cout = r_cout;
    assign Ovf  = r_ovf;

endmodule

// File: tb/tb_seg_serial_adder.sv
// tb/tb_seg_serial_adder.sv - directed and reference-model bench for seg_serial_adder
module tb_seg_serial_adder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, in_valid, in_ready, Cin, Sub, out_valid, out_ready, Cout, Ovf;
    logic [99:0] A, B, Sum;

    logic        s_rst, s_in_valid, s_in_ready, s_cin, s_sub, s_out_valid, s_out_ready, s_cout, s_ovf;
    logic [9:0]  s_a, s_b, s_sum;

    int checks = 0;
    int failures = 0;

    seg_serial_adder #(.WIDTH(100), .SEG(25)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .Cin(Cin), .Sub(Sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .Sum(Sum), .Cout(Cout), .Ovf(Ovf)
    );

    seg_serial_adder #(.WIDTH(10), .SEG(4)) dut_s (
        .clk(clk), .rst(s_rst), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .A(s_a), .B(s_b), .Cin(s_cin), .Sub(s_sub),
        .out_valid(s_out_valid), .out_ready(s_out_ready),
        .Sum(s_sum), .Cout(s_cout), .Ovf(s_ovf)
    );

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [129:0] ref_model(input logic [127:0] a, input logic [127:0] b,
                                               input logic cin, input logic sub, input int w);
        logic [128:0] full;
        logic [127:0] s;
        logic         c, o;
        if (sub) full = {1'b0, a} - {1'b0, b} - 129'(cin);
        else     full = {1'b0, a} + {1'b0, b} + 129'(cin);
        s = full[127:0] & ((128'd1 << w) - 128'd1);
        c = sub ? ~full[w] : full[w];
        if (sub) o = (a[w-1] != b[w-1]) && (s[w-1] != a[w-1]);
        else     o = (a[w-1] == b[w-1]) && (s[w-1] != a[w-1]);
        return {o, c, s};
    endfunction

    // Called at a negedge; returns at the negedge where out_valid is first seen.
    task automatic big_start(input logic [99:0] a, input logic [99:0] b, input logic cin,
                             input logic sub, output int lat);
        int w;
        A = a; B = b; Cin = cin; Sub = sub; in_valid = 1'b1;
        w = 0;
        while (!in_ready && w < 20) begin @(negedge clk); w++; end
        if (w >= 20) chk("accept_timeout", 0, 1);
        @(negedge clk);
        in_valid = 1'b0; A = '1; B = '1; Cin = 1'b1; Sub = 1'b1;
        lat = 0;
        while (!out_valid && lat < 40) begin @(negedge clk); lat++; end
    endtask

    task automatic big_ack();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("ack_out_valid_low", out_valid, 0);
    endtask

    task automatic big_op(input string tag, input logic [99:0] a, input logic [99:0] b,
                          input logic cin, input logic sub,
                          input logic [99:0] es, input logic ec, input logic eo);
        int lat;
        big_start(a, b, cin, sub, lat);
        chk({tag, "_lat"}, lat, 4);
        chk({tag, "_sum"}, Sum, es);
        chk({tag, "_cout"}, Cout, ec);
        chk({tag, "_ovf"}, Ovf, eo);
        big_ack();
    endtask

    task automatic small_op(input logic [9:0] a, input logic [9:0] b, input logic cin,
                            input logic sub, output logic [9:0] s, output logic c,
                            output logic o, output int lat);
        int w;
        s_a = a; s_b = b; s_cin = cin; s_sub = sub; s_in_valid = 1'b1;
        w = 0;
        while (!s_in_ready && w < 20) begin @(negedge clk); w++; end
        if (w >= 20) chk("s_accept_timeout", 0, 1);
        @(negedge clk);
        s_in_valid = 1'b0; s_a = '0; s_b = '0;
        lat = 0;
        while (!s_out_valid && lat < 40) begin @(negedge clk); lat++; end
        s = s_sum; c = s_cout; o = s_ovf;
        s_out_ready = 1'b1;
        @(negedge clk);
        s_out_ready = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        logic [99:0]  top = 100'd1 << 99;
        logic [127:0] ra, rb;
        logic [129:0] ex;
        logic [9:0]   ss;
        logic         sc, so, pulse;
        int           lat;

        rst = 1'b1; in_valid = 1'b0; A = '0; B = '0; Cin = 1'b0; Sub = 1'b0; out_ready = 1'b0;
        s_rst = 1'b1; s_in_valid = 1'b0; s_a = '0; s_b = '0; s_cin = 1'b0; s_sub = 1'b0; s_out_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_sum", Sum, 0);
        chk("rst_cout_ovf", {Cout, Ovf}, 0);
        rst = 1'b0; s_rst = 1'b0;
        @(negedge clk);

        big_op("ones_plus_cin", '1, '0, 1'b1, 1'b0, '0, 1'b1, 1'b0);
        big_op("sub_5_7", 100'd5, 100'd7, 1'b0, 1'b1, {{99{1'b1}}, 1'b0}, 1'b0, 1'b0);
        big_op("sub_7_5_b", 100'd7, 100'd5, 1'b1, 1'b1, 100'd1, 1'b1, 1'b0);
        big_op("ovf_pos", top - 100'd1, 100'd1, 1'b0, 1'b0, top, 1'b0, 1'b1);
        big_op("ovf_neg", top, top, 1'b0, 1'b0, '0, 1'b1, 1'b1);

        // Backpressure: result held, second operand set offered throughout.
        big_start(100'd3, 100'd4, 1'b0, 1'b0, lat);
        chk("bp_lat", lat, 4);
        for (int i = 0; i < 10; i++) begin
            A = 100'hABC; B = 100'd1; Cin = 1'b0; Sub = 1'b0; in_valid = 1'b1;
            @(negedge clk);
            chk("bp_sum_hold", Sum, 100'd7);
            chk("bp_in_ready", in_ready, 0);
            chk("bp_out_valid", out_valid, 1);
        end
        chk("bp_flags_hold", {Cout, Ovf}, 0);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("bp_xfer_out_valid", out_valid, 0);
        chk("bp_xfer_in_ready", in_ready, 1);
        @(negedge clk);
        chk("bp_second_accepted", in_ready, 0);
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 40) begin @(negedge clk); lat++; end
        chk("bp_second_lat", lat, 4);
        chk("bp_second_sum", Sum, 100'hABD);
        big_ack();

        // Reset while the counter sits at segment 2.
        A = '1; B = '0; Cin = 1'b0; Sub = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_in_ready", in_ready, 1);
        chk("mid_rst_sum", Sum, 0);
        chk("mid_rst_flags", {Cout, Ovf}, 0);
        @(negedge clk);
        rst = 1'b0;
        pulse = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (out_valid) pulse = 1'b1;
        end
        chk("mid_rst_no_pulse", pulse, 0);
        big_op("after_rst", 100'd123, 100'd456, 1'b0, 1'b0, 100'd579, 1'b0, 1'b0);

        for (int i = 0; i < 20; i++) begin
            ra = {$urandom, $urandom, $urandom, $urandom};
            rb = {$urandom, $urandom, $urandom, $urandom};
            ra[127:100] = '0; rb[127:100] = '0;
            sc = 1'($urandom); so = 1'($urandom);
            ex = ref_model(ra, rb, sc, so, 100);
            big_op("big_rand", ra[99:0], rb[99:0], sc, so, ex[99:0], ex[128], ex[129]);
        end

        small_op(10'd1023, 10'd0, 1'b1, 1'b0, ss, sc, so, lat);
        chk("s_ones_lat", lat, 3);
        chk("s_ones_sum", ss, 0);
        chk("s_ones_cout", sc, 1);
        chk("s_ones_ovf", so, 0);
        small_op(10'd511, 10'd1, 1'b0, 1'b0, ss, sc, so, lat);
        chk("s_ovf_sum", ss, 10'd512);
        chk("s_ovf_flags", {sc, so}, 2'b01);

        for (int i = 0; i < 1000; i++) begin
            ra = 128'($urandom_range(0, 1023));
            rb = 128'($urandom_range(0, 1023));
            sc = 1'($urandom); so = 1'($urandom);
            ex = ref_model(ra, rb, sc, so, 10);
            begin
                logic [9:0] gs;
                logic       gc, go;
                small_op(ra[9:0], rb[9:0], sc, so, gs, gc, go, lat);
                chk("s_rand_lat", lat, 3);
                chk("s_rand_result", {go, gc, gs}, {ex[129], ex[128], ex[9:0]});
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seg_serial_adder.md
Name: seg_serial_adder

Overview:
- Parametrised multi-cycle wide adder/subtractor for operands too wide to close timing in one combinational cycle.
- Splits WIDTH-bit operands into SEG-bit segments and adds one segment per clock, LSB first, with the carry held in a register between segments.
- Adds a subtract mode and a signed-overflow flag.
- Uses a valid/ready handshake at input and output, so it can sit between pipeline stages of the datapath.

Parameters:
- WIDTH, 100, operand/result width in bits (>=2).
- SEG, 25, segment width added per cycle (1..WIDTH).
- NSEG, derived = ceil(WIDTH/SEG), number of segment cycles; localparam, not overridable.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand set offered.
- in_ready  output  1  block can accept operands.
- A  input  WIDTH  operand A, unsigned or two's complement.
- B  input  WIDTH  operand B.
- Cin  input  1  carry-in (add) / borrow-in (subtract).
- Sub  input  1  0: Sum=A+B+Cin; 1: Sum=A-B-Cin.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts result.
- Sum  output  WIDTH  result, modulo 2^WIDTH.
- Cout  output  1  raw carry out of bit WIDTH-1 (for Sub=1: 1 = no borrow).
- Ovf  output  1  signed overflow: carry into bit WIDTH-1 XOR carry out of bit WIDTH-1.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high (ports clk, rst).
- Reset values:
  - State IDLE, segment counter 0, carry register 0.
  - in_ready=1, out_valid=0, Sum=0, Cout=0, Ovf=0.
- FSM: IDLE -> RUN -> DONE -> IDLE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready, capture A, B^{WIDTH{Sub}}, and carry = Cin^Sub into internal registers; go to RUN with counter=0.
  - Sum/Cout/Ovf keep the last result.
- RUN:
  - in_ready=0.
  - Each cycle, segment k = counter: Sum[k*SEG +: SEG] <= Aseg+Bseg+carry; carry <= segment carry-out; counter++.
  - Last segment: when WIDTH%SEG != 0, only bits up to WIDTH-1 are added. Cout is the carry out of bit WIDTH-1, not out of padded bits. Ovf is computed at bit WIDTH-1 in the same cycle.
  - After segment NSEG-1, go to DONE.
- DONE:
  - out_valid=1; Sum/Cout/Ovf stable while out_valid && !out_ready.
  - On out_ready, out_valid falls next cycle and state returns to IDLE.
  - No input acceptance in the transfer cycle.
- Latency: out_valid asserts exactly NSEG cycles after the accepting edge. Throughput is one result per NSEG+2 cycles.
- Sum bits of segments not yet written during RUN are undefined to the consumer. out_valid=0 in RUN.
- in_valid is ignored outside IDLE. Operands are sampled only at the accept edge; later input changes have no effect.
- Cin is used only at segment 0. Sub applies to the whole operation.
- SEG >= WIDTH degenerates to NSEG=1: one-cycle RUN, same protocol.
- rst asserted in any state, including mid-RUN or DONE with out_ready low: immediate return to reset values, partial result discarded, no out_valid pulse.

Decomposition:
- Shared package holds:
  - FSM state enum: IDLE, RUN, DONE.
  - Function computing ceil-divide for NSEG.
- One natural sub-module: seg_adder_slice, a combinational SEG-bit adder with a width-limit input.
  - Outputs: sum, carry-out, and carry into its top valid bit (for Ovf).
  - Instantiated once and muxed by the segment counter.

Test Plan:
- WIDTH=100/SEG=25, Sub=0, A=all ones, B=0, Cin=1 -> Sum=0, Cout=1, Ovf=0, out_valid exactly 4 cycles after accept.
- Sub=1, A=5, B=7, Cin=0 -> Sum=2^100-2, Cout=0; Sub=1, A=7, B=5, Cin=1 -> Sum=1, Cout=1.
- A=2^99-1, B=1, Cin=0, Sub=0 -> Sum=2^99, Ovf=1, Cout=0; A=B=2^99 -> Sum=0, Ovf=1, Cout=1.
- Backpressure: hold out_ready=0 for 10 cycles in DONE -> Sum/Cout/Ovf unchanged, in_ready=0, a second in_valid is not accepted until after the transfer.
- Reset mid-RUN at segment 2 -> out_valid stays 0, outputs 0, in_ready=1 next cycle; a new operation then completes correctly.
- WIDTH=10/SEG=4: A=1023, B=0, Cin=1 -> Sum=0, Cout=1 after 3 cycles; A=511, B=1 -> Ovf=1. Plus 1000 random operands checked against the reference model A±B±Cin.
